// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer
//   Packs MSB-first variable-length codes into a byte stream. After every
//   emitted 0xFF it inserts a 0x00 stuffing byte. On a flush request it pads
//   the last partial byte with 1s and drains everything that is left.
//
// Ports
//   clock, reset_n          : clock and asynchronous active-low reset
//   code_valid/code_ready   : code handshake; code_bits is right-aligned,
//                             code_len 0..MAX_LEN (larger values saturate)
//   flush / flush_done      : pad+drain request / one-cycle completion pulse
//   byte_valid/byte_ready   : output byte handshake, byte_data is the byte
//   byte_count              : bytes handshaken out, stuffing included (wraps)
module jpeg_bit_packer #(
    parameter int MAX_LEN = 16,
    parameter int ACC_W   = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               code_valid,
    output logic               code_ready,
    input  logic [MAX_LEN-1:0] code_bits,
    input  logic [4:0]         code_len,
    input  logic               flush,
    output logic               flush_done,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic [7:0]         byte_data,
    output logic [31:0]        byte_count
);

    localparam int CNT_W = $clog2(ACC_W + 1) + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stuff_q, stuff_d;
    logic               flush_pend_q, flush_pend_d;
    logic               ovld_q, ovld_d;
    logic [7:0]         obyte_q, obyte_d;
    logic [31:0]        bcnt_q, bcnt_d;
    logic               rdy_en_q;

    logic               hs_out;
    logic               load_ok;
    logic               accept;
    logic [4:0]         len;
    logic [ACC_W-1:0]   app;
    logic [ACC_W-1:0]   acc_s;
    logic [CNT_W-1:0]   cnt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [ACC_W-1:0]   ones;

    // rdy_en_q keeps code_ready low while reset is held and opens it from
    // the first edge after release.
    assign code_ready = rdy_en_q && (state_q == RUN) && !flush_pend_q &&
                        (cnt_q <= CNT_W'(ACC_W - MAX_LEN));
    assign flush_done = (state_q == DONE);
    assign byte_valid = ovld_q;
    assign byte_data  = obyte_q;
    assign byte_count = bcnt_q;

    assign hs_out  = ovld_q && byte_ready;
    assign load_ok = !ovld_q || byte_ready;
    assign accept  = code_valid && code_ready;
    assign len     = (int'(code_len) > MAX_LEN) ? 5'(MAX_LEN) : code_len;
    assign app     = ACC_W'(code_bits & ~({MAX_LEN{1'b1}} << len));
    assign ones    = '1;

    always_comb begin
        state_d      = state_q;
        stuff_d      = stuff_q;
        flush_pend_d = flush_pend_q;
        ovld_d       = ovld_q;
        obyte_d      = obyte_q;
        bcnt_d       = bcnt_q + 32'(hs_out);
        acc_s        = acc_q;
        cnt_s        = cnt_q;
        cnt_r        = '0;

        // Output register refill: a pending stuff byte beats fresh data.
        if (load_ok) begin
            if (stuff_q) begin
                obyte_d = 8'h00;
                ovld_d  = 1'b1;
                stuff_d = 1'b0;
            end else if (cnt_q >= CNT_W'(8)) begin
                obyte_d = acc_q[ACC_W-1 -: 8];
                ovld_d  = 1'b1;
                stuff_d = (acc_q[ACC_W-1 -: 8] == 8'hFF);
                acc_s   = acc_q << 8;
                cnt_s   = cnt_q - CNT_W'(8);
            end else begin
                ovld_d  = 1'b0;
            end
        end

        acc_d = acc_s;
        cnt_d = cnt_s;

        // New bits go directly below whatever remains after this cycle's
        // extraction; bits below cnt are always zero so an OR suffices.
        if (accept) begin
            acc_d = acc_s | (app << (ACC_W - int'(cnt_s) - int'(len)));
            cnt_d = cnt_s + CNT_W'(len);
        end

        case (state_q)
            RUN: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                    state_d      = PAD;
                end
            end
            PAD: begin
                // Round cnt up to a byte boundary; the gap becomes 1s.
                cnt_r   = (cnt_s + CNT_W'(7)) & ~CNT_W'(7);
                acc_d   = acc_s | ((ones >> cnt_s) & ~(ones >> cnt_r));
                cnt_d   = cnt_r;
                state_d = DRAIN;
            end
            DRAIN: begin
                if ((cnt_q == '0) && !stuff_q && load_ok)
                    state_d = DONE;
            end
            DONE: begin
                flush_pend_d = 1'b0;
                state_d      = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            acc_q        <= '0;
            cnt_q        <= '0;
            stuff_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            ovld_q       <= 1'b0;
            obyte_q      <= 8'h00;
            bcnt_q       <= '0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            stuff_q      <= stuff_d;
            flush_pend_q <= flush_pend_d;
            ovld_q       <= ovld_d;
            obyte_q      <= obyte_d;
            bcnt_q       <= bcnt_d;
            rdy_en_q     <= 1'b1;
        end
    end

endmodule
